// File: rtl/vai_txbuf_mgr.sv
`default_nettype none
// ============================================================================
// Module      : vai_txbuf_mgr
// Description : Per-channel Tx request buffer manager. Requests pass straight
//               through to the sink until the sink has been almost-full for
//               SLACK sends. After that they are parked in a small side buffer
//               that drains in arrival order once the sink frees up.
//               Optional statistics (occupancy high-water mark and drop
//               counter) are built only when VAI_TXBUF_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module vai_txbuf_mgr #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4,
  parameter int SLACK      = 5
) (
  input  logic                           Clk,
  input  logic                           Resetb,
  input  logic [NUM_CH-1:0]              in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]              sink_almfull,
  input  logic                           clr_ovf,
  output logic [NUM_CH-1:0]              out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]              src_almfull,
  output logic [NUM_CH-1:0]              ovf_sticky,
  output logic [NUM_CH*8-1:0]            buf_hwm,
  output logic [NUM_CH*16-1:0]           drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            balance_q, balance_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  src_almfull_q, src_almfull_d;
    logic                  ovf_q, ovf_d;
    logic                  stalled, empty, full, pass, deq, enq, drop, wr_en;
    logic [DATA_WIDTH-1:0] din;

    assign din = in_data[i*DATA_WIDTH +: DATA_WIDTH];

    // Routing decision (pass/enqueue/dequeue/drop) and next-state computation
    always_comb begin
      stalled = sink_almfull[i] && (balance_q >= 8'(SLACK));
      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
      // Pass-through only when nothing is queued, so ordering is never broken
      pass    = in_valid[i] && !stalled && empty;
      deq     = !stalled && !empty;
      enq     = in_valid[i] && (stalled || !empty);
      // A same-cycle dequeue frees a slot, so only a stuck-full buffer drops
      drop    = enq && full && !deq;
      wr_en   = enq && !drop;

      count_d = count_q;
      case ({wr_en, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      head_d = head_q;
      if (deq) head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
      tail_d = tail_q;
      if (wr_en) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);

      out_valid_d = pass || deq;
      out_data_d  = out_data_q;
      if (pass)     out_data_d = din;
      else if (deq) out_data_d = mem_q[head_q];

      // Balance counts sends committed while the sink is almost-full,
      // including the one being launched this cycle.
      balance_d = balance_q;
      if (!sink_almfull[i])                     balance_d = '0;
      else if (out_valid_d && balance_q != 8'hFF) balance_d = balance_q + 8'd1;

      src_almfull_d = sink_almfull[i] || (count_d != '0);

      // A new overflow takes priority over a clear request
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
    end

    // Control and output registers, synchronous active-low reset
    always_ff @(posedge Clk) begin
      if (!Resetb) begin
        head_q        <= '0;
        tail_q        <= '0;
        count_q       <= '0;
        balance_q     <= '0;
        out_valid_q   <= 1'b0;
        out_data_q    <= '0;
        src_almfull_q <= 1'b0;
        ovf_q         <= 1'b0;
      end else begin
        head_q        <= head_d;
        tail_q        <= tail_d;
        count_q       <= count_d;
        balance_q     <= balance_d;
        out_valid_q   <= out_valid_d;
        out_data_q    <= out_data_d;
        src_almfull_q <= src_almfull_d;
        ovf_q         <= ovf_d;
      end
    end

    // Payload storage; not reset since the pointers/count define validity
    always_ff @(posedge Clk) begin
      if (wr_en) mem_q[tail_q] <= din;
    end

    assign out_valid[i]                          = out_valid_q;
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH]  = out_data_q;
    assign src_almfull[i]                        = src_almfull_q;
    assign ovf_sticky[i]                         = ovf_q;

`ifdef VAI_TXBUF_STATS_EN
    logic [7:0]  hwm_q, hwm_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // High-water mark follows the post-update count; drop counter saturates
    always_comb begin
      hwm_d = hwm_q;
      if (32'(count_d) > 32'(hwm_q))
        hwm_d = (32'(count_d) > 32'd255) ? 8'hFF : 8'(count_d);
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Statistics registers
    always_ff @(posedge Clk) begin
      if (!Resetb) begin
        hwm_q      <= '0;
        drop_cnt_q <= '0;
      end else begin
        hwm_q      <= hwm_d;
        drop_cnt_q <= drop_cnt_d;
      end
    end

    assign buf_hwm[i*8 +: 8]    = hwm_q;
    assign drop_cnt[i*16 +: 16] = drop_cnt_q;
`else
    assign buf_hwm[i*8 +: 8]    = 8'd0;
    assign drop_cnt[i*16 +: 16] = 16'd0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_vai_txbuf_mgr.sv
`default_nettype none
// ============================================================================
// Module      : tb_vai_txbuf_mgr
// Description : Directed, table-driven bench for vai_txbuf_mgr (2 channels,
//               8-bit payload, DEPTH=4, SLACK=5) plus a reset-flush sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vai_txbuf_mgr;

`ifdef VAI_TXBUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Resetb;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  sink_almfull;
  logic        clr_ovf;
  logic [1:0]  out_valid;
  logic [15:0] out_data;
  logic [1:0]  src_almfull;
  logic [1:0]  ovf_sticky;
  logic [15:0] buf_hwm;
  logic [31:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  vai_txbuf_mgr #(
    .NUM_CH(2), .DATA_WIDTH(8), .DEPTH(4), .SLACK(5)
  ) dut (
    .Clk(Clk), .Resetb(Resetb), .in_valid(in_valid), .in_data(in_data),
    .sink_almfull(sink_almfull), .clr_ovf(clr_ovf), .out_valid(out_valid),
    .out_data(out_data), .src_almfull(src_almfull), .ovf_sticky(ovf_sticky),
    .buf_hwm(buf_hwm), .drop_cnt(drop_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rstn;
    logic [1:0] iv;
    logic [7:0] d0, d1;
    logic [1:0] alm;
    logic       clr;
    logic [1:0] e_ov;
    logic       c0;
    logic [7:0] e_od0;
    logic       c1;
    logic [7:0] e_od1;
    logic [1:0] e_src;
    logic [1:0] e_ovf;
    logic [7:0] e_hwm0;
    logic [15:0] e_drp0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rstn, logic [1:0] iv, logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] alm, logic clr, logic [1:0] e_ov, logic c0,
                              logic [7:0] e_od0, logic c1, logic [7:0] e_od1,
                              logic [1:0] e_src, logic [1:0] e_ovf, logic [7:0] e_hwm0,
                              logic [15:0] e_drp0);
    vec_t v;
    v.rstn = rstn; v.iv = iv; v.d0 = d0; v.d1 = d1; v.alm = alm; v.clr = clr;
    v.e_ov = e_ov; v.c0 = c0; v.e_od0 = e_od0; v.c1 = c1; v.e_od1 = e_od1;
    v.e_src = e_src; v.e_ovf = e_ovf; v.e_hwm0 = e_hwm0; v.e_drp0 = e_drp0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rstn, input logic [1:0] iv, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] alm, input logic clr);
    Resetb = rstn; in_valid = iv; in_data = {d1, d0}; sink_almfull = alm; clr_ovf = clr;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    string tag;
    Resetb = 1'b0; in_valid = '0; in_data = '0; sink_almfull = '0; clr_ovf = 1'b0;

    //              rst iv     d0     d1     alm   clr e_ov  c0 od0   c1 od1   src   ovf   hwm0 drp0
    // reset dominates live inputs
    vecs.push_back(mk(0, 2'b11, 8'hFF, 8'hFF, 2'b11, 0, 2'b00, 1, 8'h00, 1, 8'h00, 2'b00, 2'b00, 0, 0));
    // pass-through ch0, then idle, then ch1
    vecs.push_back(mk(1, 2'b01, 8'hA5, 8'h00, 2'b00, 0, 2'b01, 1, 8'hA5, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b10, 8'h00, 8'h3C, 2'b00, 0, 2'b10, 0, 8'h00, 1, 8'h3C, 2'b00, 2'b00, 0, 0));
    // ch0 sink almost-full: 5 sends allowed, ch1 unaffected
    vecs.push_back(mk(1, 2'b01, 8'h10, 8'h00, 2'b01, 0, 2'b01, 1, 8'h10, 0, 8'h00, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 8'h11, 8'h00, 2'b01, 0, 2'b01, 1, 8'h11, 0, 8'h00, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 8'h12, 8'h00, 2'b01, 0, 2'b01, 1, 8'h12, 0, 8'h00, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b11, 8'h13, 8'h77, 2'b01, 0, 2'b11, 1, 8'h13, 1, 8'h77, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 8'h14, 8'h00, 2'b01, 0, 2'b01, 1, 8'h14, 0, 8'h00, 2'b01, 2'b00, 0, 0));
    // stalled: buffered 15,16,17,18
    vecs.push_back(mk(1, 2'b01, 8'h15, 8'h00, 2'b01, 0, 2'b00, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 1, 0));
    vecs.push_back(mk(1, 2'b01, 8'h16, 8'h00, 2'b01, 0, 2'b00, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2, 0));
    vecs.push_back(mk(1, 2'b01, 8'h17, 8'h00, 2'b01, 0, 2'b00, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 3, 0));
    vecs.push_back(mk(1, 2'b01, 8'h18, 8'h00, 2'b01, 0, 2'b00, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 4, 0));
    // full: drop 19; drop 1A with clr in same cycle; then clr alone
    vecs.push_back(mk(1, 2'b01, 8'h19, 8'h00, 2'b01, 0, 2'b00, 0, 8'h00, 0, 8'h00, 2'b01, 2'b01, 4, 1));
    vecs.push_back(mk(1, 2'b01, 8'h1A, 8'h00, 2'b01, 1, 2'b00, 0, 8'h00, 0, 8'h00, 2'b01, 2'b01, 4, 2));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b01, 1, 2'b00, 0, 8'h00, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    // sink frees: buffered drain in order while new requests queue behind
    vecs.push_back(mk(1, 2'b01, 8'h1B, 8'h00, 2'b00, 0, 2'b01, 1, 8'h15, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b01, 8'h1C, 8'h00, 2'b00, 0, 2'b01, 1, 8'h16, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b01, 8'h1D, 8'h00, 2'b00, 0, 2'b01, 1, 8'h17, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b01, 8'h1E, 8'h00, 2'b00, 0, 2'b01, 1, 8'h18, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b01, 8'h1F, 8'h00, 2'b00, 0, 2'b01, 1, 8'h1B, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 1, 8'h1C, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 1, 8'h1D, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 1, 8'h1E, 0, 8'h00, 2'b01, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b01, 1, 8'h1F, 0, 8'h00, 2'b00, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 4, 2));

    foreach (vecs[n]) begin
      vec_t v;
      v = vecs[n];
      drive(v.rstn, v.iv, v.d0, v.d1, v.alm, v.clr);
      tag = $sformatf("v%0d", n);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
      chk({tag, ".src_almfull"}, 32'(src_almfull), 32'(v.e_src));
      chk({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(v.e_ovf));
      chk({tag, ".buf_hwm0"}, 32'(buf_hwm[7:0]), STATS ? 32'(v.e_hwm0) : 32'd0);
      chk({tag, ".drop_cnt0"}, 32'(drop_cnt[15:0]), STATS ? 32'(v.e_drp0) : 32'd0);
      chk({tag, ".ch1_stats"}, {buf_hwm[15:8], drop_cnt[31:16]}, 32'd0);
      if (v.c0) chk({tag, ".out_data0"}, 32'(out_data[7:0]), 32'(v.e_od0));
      if (v.c1) chk({tag, ".out_data1"}, 32'(out_data[15:8]), 32'(v.e_od1));
    end

    // Reset flush: park 3 entries, reset for one cycle, expect no stale output
    for (int k = 0; k < 8; k++) drive(1, 2'b01, 8'(8'h20 + k), 8'h00, 2'b01, 0);
    chk("prefill.out_valid", 32'(out_valid), 32'd0);
    chk("prefill.src_almfull", 32'(src_almfull), 32'd1);
    chk("prefill.buf_hwm0", 32'(buf_hwm[7:0]), STATS ? 32'd4 : 32'd0);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.src_almfull", 32'(src_almfull), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.stats", {buf_hwm, drop_cnt[15:0]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'b00, 8'h00, 8'h00, 2'b00, 0);
      chk($sformatf("post_rst%0d.out_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("post_rst%0d.src_almfull", k), 32'(src_almfull), 32'd0);
    end
    drive(1, 2'b01, 8'h5A, 8'h00, 2'b00, 0);
    chk("post_rst.pass_valid", 32'(out_valid), 32'd1);
    chk("post_rst.pass_data", 32'(out_data[7:0]), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vai_txbuf_mgr.md
VAI_TXBUF_MGR -- requirements
Module: vai_txbuf_mgr

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent Tx channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 256, payload bits per channel.
REQ-003 SHALL have parameter DEPTH, default 4, side-buffer entries per channel; any value >= 2, not necessarily a power of 2.
REQ-004 SHALL have parameter SLACK, default 5, sends allowed after sink almost-full asserts before buffering.
REQ-005 SHALL have port Clk  in  1  single clock for all logic.
REQ-006 SHALL have port Resetb  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  in  NUM_CH  per-channel request valid from AFU side.
REQ-008 SHALL have port in_data  in  NUM_CH*DATA_WIDTH  per-channel payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port sink_almfull  in  NUM_CH  almost-full from CCI-P side.
REQ-010 SHALL have port clr_ovf  in  1  clears sticky overflow flags.
REQ-011 SHALL have port out_valid  out  NUM_CH  registered request valid to CCI-P side.
REQ-012 SHALL have port out_data  out  NUM_CH*DATA_WIDTH  registered payload, same packing as in_data.
REQ-013 SHALL have port src_almfull  out  NUM_CH  almost-full to AFU side.
REQ-014 SHALL have port ovf_sticky  out  NUM_CH  sticky overflow per channel.
REQ-015 SHALL have port buf_hwm  out  NUM_CH*8  per-channel occupancy high-water mark.
REQ-016 SHALL have port drop_cnt  out  NUM_CH*16  per-channel dropped-request count.

Function
REQ-017 Channels SHALL be fully independent; every rule below applies per channel.
REQ-018 balance counter (8 bit, saturating at 255) SHALL load 0 on any cycle sink_almfull=0; otherwise it SHALL increment on each cycle out_valid=1.
REQ-019 stalled SHALL equal sink_almfull AND (balance >= SLACK), using the registered balance.
REQ-020 Pass-through: buffer empty AND not stalled AND in_valid SHALL present in_data on out_data with out_valid=1 the next cycle (latency 1).
REQ-021 Enqueue: in_valid while stalled, or while buffer non-empty, SHALL write the payload at the tail pointer.
REQ-022 Dequeue: not stalled AND buffer non-empty SHALL drive the head entry to out_data with out_valid=1 next cycle.
REQ-023 Simultaneous enqueue and dequeue SHALL leave the count unchanged and preserve strict arrival order; no conflict error.
REQ-024 Head/tail pointers SHALL wrap from DEPTH-1 to 0; count width SHALL be $clog2(DEPTH+1).
REQ-025 Enqueue at count==DEPTH without a same-cycle dequeue SHALL drop the payload, leave count and pointers unchanged, and set ovf_sticky.
REQ-026 No request SHALL both pass through and dequeue in one cycle; when neither occurs, out_valid SHALL be 0 next cycle.
REQ-027 src_almfull SHALL be registered as sink_almfull OR (next count != 0), asserted one cycle after the cause.
REQ-028 clr_ovf SHALL clear all ovf_sticky bits; a same-cycle new overflow SHALL win and leave the bit set.

Reset
REQ-029 While Resetb=0 at a Clk edge: out_valid, src_almfull, ovf_sticky, buf_hwm, drop_cnt, count, pointers and balance SHALL become 0; out_data SHALL become 0.
REQ-030 Buffer storage SHALL NOT be reset; reset mid-operation SHALL discard all buffered entries with no output.

Configuration
REQ-031 Macro VAI_TXBUF_STATS_EN defined: buf_hwm SHALL track the maximum count reached; drop_cnt SHALL increment per dropped request, saturating at 65535.
REQ-032 Macro VAI_TXBUF_STATS_EN undefined: buf_hwm and drop_cnt SHALL be constant 0, with no registers instantiated; all other behaviour is unchanged.

Verification
REQ-033 sink_almfull=0, in_valid ch0 with data 0xA5 -> out_valid ch0=1, out_data=0xA5 one cycle later; src_almfull=0.
REQ-034 sink_almfull=1, 8 back-to-back requests on ch0, SLACK=5, DEPTH=4 -> 5 pass through, 3 buffered, count=3, src_almfull=1, ovf_sticky=0.
REQ-035 Continue REQ-034 with 2 more requests -> 4th buffered, 5th dropped, ovf_sticky[0]=1, drop_cnt=1 (STATS_EN), buf_hwm=4.
REQ-036 Drop sink_almfull while in_valid continues each cycle -> buffered entries exit in arrival order, then new requests, no gaps, count reaches 0 once input stops, src_almfull falls the next cycle.
REQ-037 clr_ovf asserted in the same cycle as a new overflow -> ovf_sticky stays 1; clr_ovf alone -> 0 next cycle.
REQ-038 Resetb=0 for 1 cycle with count=3 -> count=0 and out_valid=0, and no stale entry emitted after release.
